// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM states, access-length codes,
// mc_ls encodings and grant-vector bit positions.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        STORE = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    localparam logic MC_LOAD  = 1'b0;
    localparam logic MC_STORE = 1'b1;

    localparam int unsigned GNT_FETCH = 0;
    localparam int unsigned GNT_LOAD  = 1;
    localparam int unsigned GNT_STORE = 2;

    // Byte, half and word pass through; every other code is widened to a word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            LEN_B, LEN_H, LEN_W: return len;
            default:             return LEN_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-controller signals of the arbiter. The slave modport is
// the arbiter's view; master is the view of the requesters and controller.
interface mem_arb_if;

    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_done;
    logic [31:0] fetch_inst;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_len;
    logic        ld_done;
    logic [31:0] ld_data;

    logic        st_req;
    logic [31:0] st_addr;
    logic [2:0]  st_len;
    logic [31:0] st_data;
    logic        st_done;

    logic        mc_en;
    logic        mc_ls;
    logic [2:0]  mc_len;
    logic [31:0] mc_addr;
    logic [31:0] mc_dt;
    logic        mc_done;
    logic [31:0] mc_rdata;

    modport slave (
        input  fetch_req, fetch_addr, ld_req, ld_addr, ld_len,
               st_req, st_addr, st_len, st_data, mc_done, mc_rdata,
        output fetch_done, fetch_inst, ld_done, ld_data, st_done,
               mc_en, mc_ls, mc_len, mc_addr, mc_dt
    );

    modport master (
        output fetch_req, fetch_addr, ld_req, ld_addr, ld_len,
               st_req, st_addr, st_len, st_data, mc_done, mc_rdata,
        input  fetch_done, fetch_inst, ld_done, ld_data, st_done,
               mc_en, mc_ls, mc_len, mc_addr, mc_dt
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: store > load > fetch, unless promote forces
// a pending fetch to the front. Output is one-hot or all zero.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic       promote,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = '0;
        if (promote && req[GNT_FETCH])
            gnt[GNT_FETCH] = 1'b1;
        else if (req[GNT_STORE])
            gnt[GNT_STORE] = 1'b1;
        else if (req[GNT_LOAD])
            gnt[GNT_LOAD] = 1'b1;
        else if (req[GNT_FETCH])
            gnt[GNT_FETCH] = 1'b1;
    end

endmodule

// File: rtl/mem_arb.sv
// Fetch/load/store arbiter in front of a single memory controller.
// Define MEM_ARB_AGE_EN to promote a fetch that has lost AGE_MAX arbitrations.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned AGE_MAX = 4,
    parameter logic [1:0]  IO_HI   = 2'b11
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       io_buffer_full,
    input  logic       flush,
    mem_arb_if.slave   bus
);

    state_t      state, state_nxt;
    logic [2:0]  req, gnt;
    logic        promote;
    logic        st_ok;
    logic        mc_en, take, fin_fetch, fin_load, fin_store;

    logic        mc_ls_q;
    logic [2:0]  mc_len_q;
    logic [31:0] mc_addr_q, mc_dt_q;
    logic        fetch_done_q, ld_done_q, st_done_q;
    logic [31:0] fetch_inst_q, ld_data_q;

    // An IO store is held back while the UART buffer is full; flush masks fetch.
    assign st_ok = bus.st_req && !(io_buffer_full && (bus.st_addr[17:16] == IO_HI));
    assign req   = {st_ok, bus.ld_req, bus.fetch_req && !flush};

    mem_arb_pick u_pick (
        .req     (req),
        .promote (promote),
        .gnt     (gnt)
    );

`ifdef MEM_ARB_AGE_EN
    localparam int unsigned AGE_W = $clog2(AGE_MAX + 1);
    logic [AGE_W-1:0] age;

    assign promote = (age == AGE_W'(AGE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            age <= '0;
        else if (rdy) begin
            if (flush || (state == IDLE && gnt[GNT_FETCH]))
                age <= '0;
            else if (state == IDLE && req[GNT_FETCH] && (|gnt) && !promote)
                age <= age + 1'b1;
        end
    end
`else
    assign promote = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (rdy)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt[GNT_STORE])      state_nxt = STORE;
                else if (gnt[GNT_LOAD])  state_nxt = LOAD;
                else if (gnt[GNT_FETCH]) state_nxt = FETCH;
            end
            FETCH: begin
                if (bus.mc_done)  state_nxt = IDLE;
                else if (flush)   state_nxt = DRAIN;
            end
            LOAD, STORE, DRAIN: begin
                if (bus.mc_done)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A flush coinciding with the fetch's mc_done cancels it just like DRAIN would.
    always_comb begin
        mc_en     = 1'b0;
        take      = 1'b0;
        fin_fetch = 1'b0;
        fin_load  = 1'b0;
        fin_store = 1'b0;
        case (state)
            IDLE:  take = |gnt;
            FETCH: begin
                mc_en     = 1'b1;
                fin_fetch = bus.mc_done && !flush;
            end
            LOAD: begin
                mc_en    = 1'b1;
                fin_load = bus.mc_done;
            end
            STORE: begin
                mc_en     = 1'b1;
                fin_store = bus.mc_done;
            end
            DRAIN:   mc_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_ls_q      <= MC_LOAD;
            mc_len_q     <= '0;
            mc_addr_q    <= '0;
            mc_dt_q      <= '0;
            fetch_done_q <= 1'b0;
            ld_done_q    <= 1'b0;
            st_done_q    <= 1'b0;
            fetch_inst_q <= '0;
            ld_data_q    <= '0;
        end else if (!rdy) begin
            fetch_done_q <= 1'b0;
            ld_done_q    <= 1'b0;
            st_done_q    <= 1'b0;
        end else begin
            fetch_done_q <= fin_fetch;
            ld_done_q    <= fin_load;
            st_done_q    <= fin_store;
            if (fin_fetch) fetch_inst_q <= bus.mc_rdata;
            if (fin_load)  ld_data_q    <= bus.mc_rdata;
            if (take) begin
                if (gnt[GNT_STORE]) begin
                    mc_ls_q   <= MC_STORE;
                    mc_len_q  <= norm_len(bus.st_len);
                    mc_addr_q <= bus.st_addr;
                    mc_dt_q   <= bus.st_data;
                end else if (gnt[GNT_LOAD]) begin
                    mc_ls_q   <= MC_LOAD;
                    mc_len_q  <= norm_len(bus.ld_len);
                    mc_addr_q <= bus.ld_addr;
                    mc_dt_q   <= '0;
                end else begin
                    mc_ls_q   <= MC_LOAD;
                    mc_len_q  <= LEN_W;
                    mc_addr_q <= bus.fetch_addr;
                    mc_dt_q   <= '0;
                end
            end
        end
    end

    assign bus.mc_en      = mc_en;
    assign bus.mc_ls      = mc_ls_q;
    assign bus.mc_len     = mc_len_q;
    assign bus.mc_addr    = mc_addr_q;
    assign bus.mc_dt      = mc_dt_q;
    assign bus.fetch_done = fetch_done_q;
    assign bus.ld_done    = ld_done_q;
    assign bus.st_done    = st_done_q;
    assign bus.fetch_inst = fetch_inst_q;
    assign bus.ld_data    = ld_data_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized
// transactions checked against a transaction-level priority model.
module tb_mem_arb;

    localparam int AGE = 4;

    logic clk = 1'b0;
    logic rst_n, rdy, io_buffer_full, flush;
    int   tests = 0;
    int   fails = 0;

    mem_arb_if bus ();

    mem_arb #(.AGE_MAX(AGE), .IO_HI(2'b11)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .io_buffer_full (io_buffer_full),
        .flush          (flush),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.fetch_req = 0; bus.ld_req = 0; bus.st_req = 0;
        bus.mc_done = 0; flush = 0; io_buffer_full = 0; rdy = 1;
    endtask

    task automatic do_reset();
        rst_n = 0; tick(); rst_n = 1; tick();
    endtask

    // Spec-level winner: 0 none, 1 fetch, 2 load, 3 store.
    function automatic int exp_winner(bit f, bit l, bit s, bit [1:0] hi, bit full, int age);
        bit s_ok = s && !(full && hi == 2'b11);
        if (f && age >= AGE) return 1;
        if (s_ok) return 3;
        if (l) return 2;
        if (f) return 1;
        return 0;
    endfunction

    function automatic logic [2:0] exp_len(logic [2:0] l);
        return (l == 3'd1 || l == 3'd2 || l == 3'd4) ? l : 3'd4;
    endfunction

    task automatic test_reset();
        logic [69:0] mc_all;
        logic [66:0] out_all;
        rst_n = 0; rdy = 1; flush = 0; io_buffer_full = 1;
        bus.fetch_req = 1; bus.ld_req = 1; bus.st_req = 1; bus.mc_done = 1;
        bus.fetch_addr = $urandom; bus.ld_addr = $urandom; bus.st_addr = $urandom;
        bus.ld_len = 3'd2; bus.st_len = 3'd1; bus.st_data = $urandom; bus.mc_rdata = $urandom;
        tick(); tick();
        mc_all  = {bus.mc_en, bus.mc_ls, bus.mc_len, bus.mc_addr, bus.mc_dt};
        out_all = {bus.fetch_done, bus.ld_done, bus.st_done, bus.fetch_inst, bus.ld_data};
        tests++;
        if (mc_all !== '0) begin fails++; $display("FAIL reset_mc: got %h exp 0", mc_all); end
        tests++;
        if (out_all !== '0) begin fails++; $display("FAIL reset_out: got %h exp 0", out_all); end
        idle_inputs();
        rst_n = 1; tick(); tick();
        tests++;
        if (bus.mc_en !== 1'b0) begin fails++; $display("FAIL reset_idle: mc_en %b exp 0", bus.mc_en); end
    endtask

    task automatic test_load_then_fetch();
        logic [31:0] la = 32'h0000_1230, fa = 32'h0000_8000, rd = $urandom;
        bus.ld_req = 1; bus.ld_addr = la; bus.ld_len = 3'd2;
        bus.fetch_req = 1; bus.fetch_addr = fa;
        tick();
        tests++;
        if ({bus.mc_en, bus.mc_ls, bus.mc_len, bus.mc_addr} !== {1'b1, 1'b0, 3'd2, la}) begin
            fails++; $display("FAIL lf_grant_load: got en=%b ls=%b len=%0d addr=%h exp 1 0 2 %h",
                              bus.mc_en, bus.mc_ls, bus.mc_len, bus.mc_addr, la);
        end
        bus.ld_req = 0; bus.ld_addr = 32'hdead_beef;
        tick(); tick();
        tests++;
        if ({bus.mc_en, bus.mc_addr, bus.ld_done} !== {1'b1, la, 1'b0}) begin
            fails++; $display("FAIL lf_hold: en=%b addr=%h done=%b exp 1 %h 0", bus.mc_en, bus.mc_addr, bus.ld_done, la);
        end
        bus.mc_done = 1; bus.mc_rdata = rd;
        tick();
        bus.mc_done = 0;
        tests++;
        if ({bus.ld_done, bus.fetch_done, bus.mc_en, bus.ld_data} !== {1'b1, 1'b0, 1'b0, rd}) begin
            fails++; $display("FAIL lf_ld_done: done=%b fdone=%b en=%b data=%h exp 1 0 0 %h",
                              bus.ld_done, bus.fetch_done, bus.mc_en, bus.ld_data, rd);
        end
        tick();
        tests++;
        if ({bus.mc_en, bus.mc_addr, bus.ld_done} !== {1'b1, fa, 1'b0}) begin
            fails++; $display("FAIL lf_fetch_grant: en=%b addr=%h ld_done=%b exp 1 %h 0", bus.mc_en, bus.mc_addr, bus.ld_done, fa);
        end
        bus.fetch_req = 0; bus.mc_done = 1; rd = $urandom; bus.mc_rdata = rd;
        tick();
        bus.mc_done = 0;
        tests++;
        if ({bus.fetch_done, bus.fetch_inst} !== {1'b1, rd}) begin
            fails++; $display("FAIL lf_fetch_done: done=%b inst=%h exp 1 %h", bus.fetch_done, bus.fetch_inst, rd);
        end
        tick();
        tests++;
        if ({bus.fetch_done, bus.mc_en} !== 2'b00) begin
            fails++; $display("FAIL lf_pulse_width: done=%b en=%b exp 0 0", bus.fetch_done, bus.mc_en);
        end
    endtask

    task automatic test_io_block();
        logic [31:0] fa = 32'h0000_4440, sd = $urandom;
        bus.st_req = 1; bus.st_addr = 32'h0003_0000; bus.st_len = 3'd1; bus.st_data = sd;
        io_buffer_full = 1; bus.fetch_req = 1; bus.fetch_addr = fa;
        tick();
        tests++;
        if ({bus.mc_en, bus.mc_ls, bus.mc_addr} !== {1'b1, 1'b0, fa}) begin
            fails++; $display("FAIL io_fetch_first: en=%b ls=%b addr=%h exp 1 0 %h", bus.mc_en, bus.mc_ls, bus.mc_addr, fa);
        end
        bus.fetch_req = 0; bus.mc_done = 1;
        tick();
        bus.mc_done = 0;
        tick();
        tests++;
        if (bus.mc_en !== 1'b0) begin fails++; $display("FAIL io_blocked: mc_en %b exp 0", bus.mc_en); end
        io_buffer_full = 0;
        tick();
        tests++;
        if ({bus.mc_en, bus.mc_ls, bus.mc_len, bus.mc_addr, bus.mc_dt} !== {1'b1, 1'b1, 3'd1, 32'h0003_0000, sd}) begin
            fails++; $display("FAIL io_store_grant: en=%b ls=%b len=%0d addr=%h dt=%h exp 1 1 1 00030000 %h",
                              bus.mc_en, bus.mc_ls, bus.mc_len, bus.mc_addr, bus.mc_dt, sd);
        end
        bus.st_req = 0; io_buffer_full = 1;
        tick();
        tests++;
        if ({bus.mc_en, bus.mc_ls} !== 2'b11) begin fails++; $display("FAIL io_full_late: en=%b ls=%b exp 1 1", bus.mc_en, bus.mc_ls); end
        bus.mc_done = 1;
        tick();
        bus.mc_done = 0; io_buffer_full = 0;
        tests++;
        if (bus.st_done !== 1'b1) begin fails++; $display("FAIL io_st_done: got %b exp 1", bus.st_done); end
        tick();
    endtask

    task automatic test_flush();
        bus.fetch_req = 1; bus.fetch_addr = 32'h0000_0100;
        tick();
        bus.fetch_req = 0;
        tick();
        flush = 1;
        tick();
        flush = 0;
        tests++;
        if ({bus.mc_en, bus.mc_addr} !== {1'b1, 32'h0000_0100}) begin
            fails++; $display("FAIL flush_drain_en: en=%b addr=%h exp 1 00000100", bus.mc_en, bus.mc_addr);
        end
        tick();
        bus.mc_done = 1;
        tick();
        bus.mc_done = 0;
        tests++;
        if ({bus.fetch_done, bus.mc_en} !== 2'b00) begin
            fails++; $display("FAIL flush_no_done: done=%b en=%b exp 0 0", bus.fetch_done, bus.mc_en);
        end
        tick();
        tests++;
        if ({bus.fetch_done, bus.mc_en} !== 2'b00) begin
            fails++; $display("FAIL flush_idle: done=%b en=%b exp 0 0", bus.fetch_done, bus.mc_en);
        end
        bus.fetch_req = 1; flush = 1;
        tick();
        flush = 0;
        tests++;
        if (bus.mc_en !== 1'b0) begin fails++; $display("FAIL flush_idle_mask: mc_en %b exp 0", bus.mc_en); end
        tick();
        tests++;
        if (bus.mc_en !== 1'b1) begin fails++; $display("FAIL flush_then_fetch: mc_en %b exp 1", bus.mc_en); end
        bus.fetch_req = 0; bus.mc_done = 1;
        tick();
        bus.mc_done = 0;
        tick();
    endtask

    task automatic test_rdy_freeze();
        logic [31:0] sa = 32'h0001_2344, sd = $urandom;
        bus.st_req = 1; bus.st_addr = sa; bus.st_len = 3'd2; bus.st_data = sd;
        tick();
        bus.st_req = 0;
        tick();
        rdy = 0;
        for (int i = 0; i < 5; i++) begin
            bus.ld_req = 1; bus.ld_addr = $urandom; io_buffer_full = 1'($urandom);
            tick();
            tests++;
            if ({bus.mc_en, bus.mc_ls, bus.mc_len, bus.mc_addr, bus.mc_dt, bus.st_done, bus.ld_done} !==
                {1'b1, 1'b1, 3'd2, sa, sd, 1'b0, 1'b0}) begin
                fails++; $display("FAIL rdy_frozen[%0d]: en=%b ls=%b len=%0d addr=%h dt=%h sd=%b exp 1 1 2 %h %h 0",
                                  i, bus.mc_en, bus.mc_ls, bus.mc_len, bus.mc_addr, bus.mc_dt, bus.st_done, sa, sd);
            end
        end
        rdy = 1; bus.ld_req = 0; io_buffer_full = 0; bus.mc_done = 1;
        tick();
        bus.mc_done = 0;
        tests++;
        if ({bus.st_done, bus.mc_en} !== 2'b10) begin
            fails++; $display("FAIL rdy_st_done: done=%b en=%b exp 1 0", bus.st_done, bus.mc_en);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.ld_req = 1; bus.ld_addr = 32'h0000_0040; bus.ld_len = 3'd4;
        tick();
        bus.ld_req = 0; bus.mc_done = 1;
        #1 rst_n = 0;
        #1;
        tests++;
        if (bus.mc_en !== 1'b0) begin fails++; $display("FAIL rst_mid_async: mc_en %b exp 0", bus.mc_en); end
        tick();
        tests++;
        if (bus.ld_done !== 1'b0) begin fails++; $display("FAIL rst_mid_done: ld_done %b exp 0", bus.ld_done); end
        rst_n = 1; bus.mc_done = 0;
        tick();
        tests++;
        if ({bus.ld_done, bus.mc_en} !== 2'b00) begin
            fails++; $display("FAIL rst_mid_after: done=%b en=%b exp 0 0", bus.ld_done, bus.mc_en);
        end
    endtask

    task automatic test_random();
        int age_m = 0;
        int w;
        logic [31:0] rd, exp_addr;
        logic [2:0]  exp_done;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            bus.fetch_req = 1'($urandom); bus.ld_req = 1'($urandom); bus.st_req = 1'($urandom);
            bus.fetch_addr = $urandom; bus.ld_addr = $urandom; bus.st_addr = $urandom;
            bus.ld_len = 3'($urandom); bus.st_len = 3'($urandom); bus.st_data = $urandom;
            io_buffer_full = 1'($urandom);
`ifdef MEM_ARB_AGE_EN
            w = exp_winner(bus.fetch_req, bus.ld_req, bus.st_req, bus.st_addr[17:16], io_buffer_full, age_m);
            if (w == 1) age_m = 0;
            else if (w != 0 && bus.fetch_req) age_m = (age_m + 1 > AGE) ? AGE : age_m + 1;
`else
            w = exp_winner(bus.fetch_req, bus.ld_req, bus.st_req, bus.st_addr[17:16], io_buffer_full, age_m);
`endif
            exp_addr = (w == 3) ? bus.st_addr : (w == 2) ? bus.ld_addr : bus.fetch_addr;
            tick();
            if (w == 0) begin
                tests++;
                if (bus.mc_en !== 1'b0) begin fails++; $display("FAIL rnd_none[%0d]: mc_en %b exp 0", n, bus.mc_en); end
                continue;
            end
            tests++;
            if ({bus.mc_en, bus.mc_ls, bus.mc_addr} !== {1'b1, (w == 3), exp_addr}) begin
                fails++; $display("FAIL rnd_grant[%0d]: en=%b ls=%b addr=%h exp 1 %b %h", n,
                                  bus.mc_en, bus.mc_ls, bus.mc_addr, (w == 3), exp_addr);
            end
            if (w != 1) begin
                tests++;
                if (bus.mc_len !== exp_len((w == 3) ? bus.st_len : bus.ld_len)) begin
                    fails++; $display("FAIL rnd_len[%0d]: got %0d exp %0d", n, bus.mc_len,
                                      exp_len((w == 3) ? bus.st_len : bus.ld_len));
                end
            end
            if (w == 3) begin
                tests++;
                if (bus.mc_dt !== bus.st_data) begin fails++; $display("FAIL rnd_dt[%0d]: got %h exp %h", n, bus.mc_dt, bus.st_data); end
            end
            bus.fetch_req = 1'($urandom); bus.ld_req = 1'($urandom); bus.st_req = 1'($urandom);
            bus.fetch_addr = $urandom; bus.ld_addr = $urandom; bus.st_addr = $urandom;
            io_buffer_full = 1'($urandom);
            repeat ($urandom_range(0, 3)) begin
                tick();
                tests++;
                if ({bus.mc_en, bus.mc_addr} !== {1'b1, exp_addr}) begin
                    fails++; $display("FAIL rnd_stable[%0d]: en=%b addr=%h exp 1 %h", n, bus.mc_en, bus.mc_addr, exp_addr);
                end
            end
            bus.fetch_req = 0; bus.ld_req = 0; bus.st_req = 0; io_buffer_full = 0;
            rd = $urandom; bus.mc_rdata = rd; bus.mc_done = 1;
            tick();
            bus.mc_done = 0;
            exp_done = {w == 1, w == 2, w == 3};
            tests++;
            if ({bus.fetch_done, bus.ld_done, bus.st_done, bus.mc_en} !== {exp_done, 1'b0}) begin
                fails++; $display("FAIL rnd_done[%0d]: got %b en=%b exp %b 0", n,
                                  {bus.fetch_done, bus.ld_done, bus.st_done}, bus.mc_en, exp_done);
            end
            if (w != 3) begin
                tests++;
                if (((w == 1) ? bus.fetch_inst : bus.ld_data) !== rd) begin
                    fails++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", n, (w == 1) ? bus.fetch_inst : bus.ld_data, rd);
                end
            end
            tick();
            tests++;
            if ({bus.fetch_done, bus.ld_done, bus.st_done, bus.mc_en} !== 4'b0000) begin
                fails++; $display("FAIL rnd_quiet[%0d]: got %b exp 0000", n, {bus.fetch_done, bus.ld_done, bus.st_done, bus.mc_en});
            end
        end
    endtask

`ifdef MEM_ARB_AGE_EN
    task automatic test_aging();
        do_reset();
        bus.fetch_req = 1; bus.fetch_addr = 32'h0000_F000;
        bus.ld_addr = 32'h0000_0200; bus.ld_len = 3'd4;
        for (int i = 0; i < AGE; i++) begin
            bus.ld_req = 1;
            tick();
            tests++;
            if ({bus.mc_en, bus.mc_addr} !== {1'b1, 32'h0000_0200}) begin
                fails++; $display("FAIL age_load[%0d]: en=%b addr=%h exp 1 00000200", i, bus.mc_en, bus.mc_addr);
            end
            bus.ld_req = 0; bus.mc_done = 1;
            tick();
            bus.mc_done = 0;
        end
        bus.ld_req = 1;
        tick();
        tests++;
        if ({bus.mc_en, bus.mc_addr} !== {1'b1, 32'h0000_F000}) begin
            fails++; $display("FAIL age_promote: en=%b addr=%h exp 1 0000f000", bus.mc_en, bus.mc_addr);
        end
        bus.ld_req = 0; bus.fetch_req = 0; bus.mc_done = 1;
        tick();
        bus.mc_done = 0;
        tick();
    endtask
`endif

    initial begin
        bus.mc_rdata = '0;
        test_reset();
        test_load_then_fetch();
        test_io_block();
        test_flush();
        test_rdy_freeze();
        test_reset_mid();
`ifdef MEM_ARB_AGE_EN
        test_aging();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
